pipelined_shifter: RTL
======================

// Module: pipelined_shifter
// PURPOSE
//  Parametrised, pipelined barrel shifter with four shift modes and a valid/ready stream interface.
//  It replaces the single-cycle combinational right shifter inside the ALU path.
//  There is one mux layer per shift-amount bit, and a register follows each layer.
//  Full throughput (1 op/cycle) with backpressure; an opaque tag travels with each op.
// PARAMETERS
//  WIDTH      32  data width; power of two, >= 4
//  TAG_W      4   width of the sideband tag carried alongside each op
//  PIPELINED  1   1: register after every layer (latency SHAMT_W); 0: one output register (latency 1)
//  SHAMT_W    $clog2(WIDTH)  localparam; shift-amount width
// PORTS
//  clock      in   1        rising-edge clock
//  reset_n    in   1        synchronous, active-low reset
//  in_valid   in   1        input op present
//  in_ready   out  1        block can accept an op this cycle
//  in_data    in   WIDTH    operand
//  in_shamt   in   SHAMT_W  shift amount, 0..WIDTH-1
//  in_op      in   2        00 SRL, 01 SRA, 10 SLL, 11 ROR (rotate right)
//  in_tag     in   TAG_W    sideband tag, returned unmodified
//  out_valid  out  1        result present
//  out_ready  in   1        consumer accepts result
//  out_data   out  WIDTH    shifted result
//  out_tag    out  TAG_W    tag of the op producing out_data
// BEHAVIOUR
//  - Handshake: transfer occurs when valid & ready are both high at a rising edge. The producer must hold valid/data stable until transfer.
//  - Layer k (k=0..SHAMT_W-1) shifts by 2^k when shamt[k]=1. Fill rules per layer:
//    SRL zero-fill MSBs; SRA fill with the operand's original bit WIDTH-1; SLL zero-fill LSBs; ROR wraps LSBs into MSBs.
//  - Each stage register holds: valid, data, shamt (remaining bits), op, tag, and the sign bit captured at input.
//  - Stage i advances when it is empty or stage i+1 advances. The final stage advances when out_ready=1 or out_valid=0.
//    in_ready = stage0 empty | stage0 advancing. It is a combinational function of stage valids and out_ready.
//  - Latency: with PIPELINED=1, out_valid rises exactly SHAMT_W cycles after the accepting edge when there are no stalls; 5 for WIDTH=32.
//    With PIPELINED=0 the latency is 1 cycle.
//  - Back-to-back accepts produce back-to-back results. Ordering is strictly FIFO. Under stall no op is dropped or duplicated.
//  - Full pipeline with out_ready=0: in_ready=0. Releasing out_ready raises in_ready in the same cycle.
//  - shamt=0: out_data=in_data for all ops. Ops with shamt >= WIDTH cannot be expressed.
//  - While out_valid=1 and out_ready=0, out_data and out_tag hold stable.
//  - Reset (reset_n=0 at edge): all stage valids cleared, including mid-operation; in-flight ops are discarded.
//    out_valid=0, out_data=0, out_tag=0. in_ready is forced 0 while reset_n=0 and is 1 on the first cycle after release.
//  - The op field is not latched globally. Every op uses its own mode, so mixed-mode streams are legal.
// TESTING (WIDTH=32, TAG_W=4, PIPELINED=1)
//  1. SRA 0x80000000, shamt 31 -> 0xFFFFFFFF. SRL same operand -> 0x00000001. out_valid exactly 5 cycles after accept.
//  2. SLL 0x00000001 shamt 16 -> 0x00010000. ROR 0x12345678 shamt 8 -> 0x78123456. Any op with shamt 0 -> operand unchanged.
//  3. Stream 8 mixed ops (tags 0..7) with out_ready=1 -> 8 consecutive out_valid cycles, tags 0..7 in order.
//  4. Hold out_ready=0 and offer 8 ops -> exactly 5 accepted, then in_ready=0, out_data stable.
//     Release -> all 8 emerge in order, none lost or repeated.
//  5. Assert reset_n=0 with 3 ops in flight -> next cycle out_valid=0, out_data=0.
//     After release no stale result appears; in_ready=1.
//  6. Random ops vs a reference model (>>, >>>, <<, rotate) for 10k ops with random out_ready -> zero mismatches.
//     Also run PIPELINED=0, latency 1.

Source files
------------

// File: rtl/pipelined_shifter_if.sv
// Stream interface for the pipelined barrel shifter.
// Input side: an op (operand, shift amount, mode, tag) with a valid/ready handshake.
// Output side: the result with its tag, also with a valid/ready handshake.
interface pipelined_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;
    logic [TAG_W-1:0]   in_tag;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;

    // Producer of ops and consumer of results.
    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    // The shifter itself.
    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: SRL, SRA, SLL and ROR on a valid/ready stream.
// One mux layer per shift-amount bit; layer k shifts by 2^k when shamt[k] is set.
// PIPELINED=1 registers after every layer (latency SHAMT_W), PIPELINED=0 uses a
// single output register behind all layers (latency 1).
// WIDTH must be a power of two and at least 4.
// Each stage carries its own op, tag, remaining shamt and the operand's original
// sign bit, so mixed-mode streams flow without any global mode state.
module pipelined_shifter #(
    parameter int WIDTH     = 32,
    parameter int TAG_W     = 4,
    parameter int PIPELINED = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    pipelined_shifter_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int NSTG    = (PIPELINED != 0) ? SHAMT_W : 1;

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;

    typedef struct packed {
        logic [WIDTH-1:0]   data;
        logic [SHAMT_W-1:0] shamt;
        logic [1:0]         op;
        logic [TAG_W-1:0]   tag;
        logic               sign;
    } stage_t;

    // One shift layer by a fixed amount; SRA fills from the sign captured at
    // input, which stays correct even after earlier layers already shifted.
    function automatic logic [WIDTH-1:0] shift_layer(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       op,
        input logic             sign,
        input int               amt
    );
        logic [WIDTH-1:0] fill;
        fill = ~({WIDTH{1'b1}} >> amt);
        case (op)
            OP_SRL:  return d >> amt;
            OP_SRA:  return (d >> amt) | (sign ? fill : '0);
            OP_SLL:  return d << amt;
            default: return (d >> amt) | (d << (WIDTH - amt));
        endcase
    endfunction

    // Applies layers lo..hi in order, each gated by its shamt bit.
    function automatic logic [WIDTH-1:0] apply_layers(
        input logic [WIDTH-1:0]   d,
        input logic [SHAMT_W-1:0] shamt,
        input logic [1:0]         op,
        input logic               sign,
        input int                 lo,
        input int                 hi
    );
        logic [WIDTH-1:0] r;
        r = d;
        for (int k = lo; k <= hi; k++) begin
            if (shamt[k]) begin
                r = shift_layer(r, op, sign, 1 << k);
            end
        end
        return r;
    endfunction

    logic   [NSTG-1:0] stg_valid;
    logic   [NSTG-1:0] advance;
    stage_t [NSTG-1:0] stg_payload;
    logic              in_ready_int;

    // Stall chain: a stage loads when it is empty or its successor moves on;
    // evaluated from the output end back towards the input.
    always_comb begin
        advance = '0;
        advance[NSTG-1] = bus.out_ready | ~stg_valid[NSTG-1];
        for (int i = NSTG - 2; i >= 0; i--) begin
            advance[i] = ~stg_valid[i] | advance[i+1];
        end
    end

    assign in_ready_int = reset_n & advance[0];
    assign bus.in_ready = in_ready_int;

    for (genvar g = 0; g < NSTG; g++) begin : g_stage
        localparam int LO = (PIPELINED != 0) ? g : 0;
        localparam int HI = (PIPELINED != 0) ? g : SHAMT_W - 1;

        stage_t src;
        logic   src_valid;
        stage_t shifted;
        stage_t payload_q;
        logic   valid_q;

        if (g == 0) begin : g_head
            assign src_valid = bus.in_valid & in_ready_int;
            assign src = {bus.in_data, bus.in_shamt, bus.in_op, bus.in_tag,
                          bus.in_data[WIDTH-1]};
        end else begin : g_body
            assign src_valid = stg_valid[g-1];
            assign src       = stg_payload[g-1];
        end

        // Mux layer(s) belonging to this stage; everything else passes through.
        always_comb begin
            shifted      = src;
            shifted.data = apply_layers(src.data, src.shamt, src.op, src.sign, LO, HI);
        end

        // Stage register: reset drops in-flight ops; payload only moves with a real op.
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                valid_q   <= 1'b0;
                payload_q <= '0;
            end else if (advance[g]) begin
                valid_q <= src_valid;
                if (src_valid) begin
                    payload_q <= shifted;
                end
            end
        end

        assign stg_valid[g]   = valid_q;
        assign stg_payload[g] = payload_q;
    end

    assign bus.out_valid = stg_valid[NSTG-1];
    assign bus.out_data  = stg_payload[NSTG-1].data;
    assign bus.out_tag   = stg_payload[NSTG-1].tag;

    logic unused_tail;
    assign unused_tail = ^{stg_payload[NSTG-1].shamt, stg_payload[NSTG-1].op,
                           stg_payload[NSTG-1].sign};
endmodule
